// File: rtl/multiplier_control.sv
// Sequencer for the shift-add multiplier datapath: load, WORD_LENGTH add/shift
// iterations, then a one-cycle ready pulse.
module multiplier_control #(
  parameter int unsigned WORD_LENGTH = 4,
  parameter int unsigned CNT_WIDTH   = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 mplr_lsb,
  output logic                 load_en,
  output logic                 acc_en,
  output logic                 shift_en,
  output logic                 mux_sel,
  output logic                 busy,
  output logic                 ready,
  output logic [CNT_WIDTH-1:0] count
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_CALC = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [CNT_WIDTH-1:0] LAST_ITER = CNT_WIDTH'(WORD_LENGTH - 1);

  state_t               r_state;
  state_t               w_state_nxt;
  logic [CNT_WIDTH-1:0] r_count;
  logic [CNT_WIDTH-1:0] w_count_nxt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_count <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_count <= w_count_nxt;
    end
  end

  // Counter is zeroed on entry to LOAD so it reads 0 for the whole operation setup.
  always_comb begin
    w_state_nxt = r_state;
    w_count_nxt = r_count;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = S_LOAD;
          w_count_nxt = '0;
        end
      end
      S_LOAD: begin
        w_state_nxt = S_CALC;
        w_count_nxt = '0;
      end
      S_CALC: begin
        if (r_count == LAST_ITER) begin
          w_state_nxt = S_DONE;
        end else begin
          w_count_nxt = r_count + CNT_WIDTH'(1);
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_count_nxt = '0;
      end
    endcase
  end

  // Control strobes decode straight from the state register; mux_sel is the only Mealy term.
  always_comb begin
    load_en  = 1'b0;
    acc_en   = 1'b0;
    shift_en = 1'b0;
    mux_sel  = 1'b0;
    ready    = 1'b0;
    busy     = (r_state != S_IDLE);
    case (r_state)
      S_LOAD: load_en = 1'b1;
      S_CALC: begin
        acc_en   = 1'b1;
        shift_en = 1'b1;
        mux_sel  = mplr_lsb;
      end
      S_DONE: ready = 1'b1;
      default: ;
    endcase
  end

  assign count = r_count;

endmodule

// File: tb/tb_multiplier_control.sv
// Bench for multiplier_control with a behavioural shift-add datapath attached;
// products are scoreboarded and checked on each ready pulse.
module tb_multiplier_control;

  localparam int unsigned WL = 4;
  localparam int unsigned CW = 3;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic          mplr_lsb;
  logic          load_en, acc_en, shift_en, mux_sel, busy, ready;
  logic [CW-1:0] count;

  logic [WL-1:0]   a_in, b_in;
  logic [2*WL-1:0] dp_mcand, dp_acc;
  logic [WL-1:0]   dp_mplr;

  int n_checks = 0;
  int n_errors = 0;
  int n_ready  = 0;
  int n_load   = 0;
  logic [2*WL-1:0] sb_q[$];

  multiplier_control #(.WORD_LENGTH(WL), .CNT_WIDTH(CW)) u_dut (
    .clk      (clk),
    .reset    (rst_n),
    .start    (start),
    .mplr_lsb (mplr_lsb),
    .load_en  (load_en),
    .acc_en   (acc_en),
    .shift_en (shift_en),
    .mux_sel  (mux_sel),
    .busy     (busy),
    .ready    (ready),
    .count    (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural operand/accumulator registers driven by the controller strobes.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dp_mcand <= '0;
      dp_mplr  <= '0;
      dp_acc   <= '0;
    end else if (load_en) begin
      dp_mcand <= {{WL{1'b0}}, a_in};
      dp_mplr  <= b_in;
      dp_acc   <= '0;
    end else begin
      if (acc_en && mux_sel) dp_acc <= dp_acc + dp_mcand;
      if (shift_en) begin
        dp_mplr  <= dp_mplr >> 1;
        dp_mcand <= dp_mcand << 1;
      end
    end
  end
  assign mplr_lsb = dp_mplr[0];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Scoreboard pop on every ready pulse.
  always @(negedge clk) begin
    if (load_en) n_load++;
    if (ready) begin
      n_ready++;
      if (sb_q.size() == 0) check("sb_unexpected_ready", 32'd1, 32'd0);
      else check("product", 32'(dp_acc), 32'(sb_q.pop_front()));
    end
  end

  // One operation; cycle k=1 is the cycle after the start edge.
  task automatic run_op(input logic [WL-1:0] a, input logic [WL-1:0] b, input bit repulse);
    int ready_k = 0;
    int loads0, readys0;
    int calc_n = 0;
    logic [WL-1:0]    mux_seq = '0;
    logic [3*WL-1:0]  cnt_seq = '0;
    a_in = a;
    b_in = b;
    sb_q.push_back(8'(a * b));
    loads0  = n_load;
    readys0 = n_ready;
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    @(negedge clk) start = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      if (k > 1) @(negedge clk);
      if (acc_en && calc_n < int'(WL)) begin
        mux_seq[calc_n] = mux_sel;
        cnt_seq[3*calc_n +: 3] = count;
        calc_n++;
      end
      if (ready && ready_k == 0) begin
        ready_k = k;
        check("count_in_done", 32'(count), 32'(WL - 1));
      end
      if (repulse && k == 3) start = 1'b1;
      if (repulse && k == 4) start = 1'b0;
    end
    check("ready_latency", 32'(ready_k), 32'(WL + 2));
    check("calc_cycles", 32'(calc_n), 32'(WL));
    check("mux_sel_seq", 32'(mux_seq), 32'(b));
    check("count_seq", 32'(cnt_seq), {20'd0, 3'd3, 3'd2, 3'd1, 3'd0});
    check("load_pulses", 32'(n_load - loads0), 32'd1);
    check("ready_pulses", 32'(n_ready - readys0), 32'd1);
    check("idle_after", 32'(busy), 32'd0);
  endtask

  initial begin
    int r0, l0, mux_high;
    int rk[$];
    logic [WL-1:0] ra, rb;
    start = 1'b0;
    a_in  = '0;
    b_in  = '0;
    rst_n = 1'b1;
    #3 rst_n = 1'b0;
    #1;
    check("rst_outputs", {26'd0, load_en, acc_en, shift_en, mux_sel, busy, ready}, 32'd0);
    check("rst_count", 32'(count), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (busy | ready | load_en | acc_en | shift_en | mux_sel)
        check("idle_outputs", {26'd0, load_en, acc_en, shift_en, mux_sel, busy, ready}, 32'd0);
    end
    check("idle_busy", 32'(busy), 32'd0);

    // mplr_lsb sequence 1,0,1,1 comes from multiplier 13
    run_op(4'd11, 4'd13, 1'b0);
    run_op(4'd13, 4'd11, 1'b0);
    run_op(4'd15, 4'd15, 1'b0);
    run_op(4'd0,  4'd9,  1'b0);
    run_op(4'd7,  4'd6,  1'b1);
    for (int i = 0; i < 4; i++) begin
      ra = 4'($urandom_range(15));
      rb = 4'($urandom_range(15));
      run_op(ra, rb, 1'b0);
    end

    // Reset during the 2nd CALC cycle aborts without a ready pulse.
    a_in = 4'd15;
    b_in = 4'd15;
    r0 = n_ready;
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    @(negedge clk) start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("abort_in_calc", 32'(acc_en), 32'd1);
    rst_n = 1'b0;
    #1;
    check("abort_outputs", {26'd0, load_en, acc_en, shift_en, mux_sel, busy, ready}, 32'd0);
    check("abort_count", 32'(count), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    check("abort_no_ready", 32'(n_ready - r0), 32'd0);
    run_op(4'd9, 4'd14, 1'b0);

    // start held high for 20 cycles with multiplier 0.
    a_in = 4'd10;
    b_in = 4'd0;
    repeat (3) sb_q.push_back(8'd0);
    r0 = n_ready;
    l0 = n_load;
    mux_high = 0;
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= 26; k++) begin
      @(negedge clk);
      if (ready) rk.push_back(k);
      if (mux_sel) mux_high++;
      if (k == 20) start = 1'b0;
    end
    check("held_ready_pulses", 32'(n_ready - r0), 32'd3);
    check("held_load_pulses", 32'(n_load - l0), 32'd3);
    check("held_mux_high", 32'(mux_high), 32'd0);
    check("held_ready_k0", (rk.size() > 0) ? 32'(rk[0]) : 32'hFFFF, 32'd6);
    check("held_ready_k1", (rk.size() > 1) ? 32'(rk[1]) : 32'hFFFF, 32'd13);
    check("held_ready_k2", (rk.size() > 2) ? 32'(rk[2]) : 32'hFFFF, 32'd20);
    check("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
